// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer RAM arbiter.
// Slot encoding, pixel width and 640x480 geometry.
package fb_arb_pkg;

  localparam int XRES      = 640;
  localparam int YRES      = 480;
  localparam int PIX_W     = 8;  // RGB332
  localparam int FB_ADDR_W = $clog2(XRES * YRES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } slot_e;

endpackage

// File: rtl/fb_ram_arbiter_if.sv
// Pixel-writer handshake into the framebuffer arbiter.
// master = writer (camera/UART loader), slave = arbiter.
interface fb_ram_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_W,
  parameter int DATA_WIDTH = PIX_W
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/fb_wr_fifo.sv
// Generic synchronous FIFO, power-of-2 depth, full/empty told apart by level.
// Latency: pushed entry visible at dout the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
module fb_wr_fifo #(
  parameter int  WIDTH = 27,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fb_ram_arbiter.sv
// Shares single-port framebuffer RAM: VGA reads win, buffered writes fill idle/blanking slots; FB_ARB_STATS_EN adds stall/drop counters.
// Latency: vga_addr at t -> ram_addr at t+1 -> vga_rdata valid from t+3; queued write issues >= 1 cycle after push.
// Backpressure: wr_ready = !fifo_full, no same-cycle bypass; a full FIFO refuses a push even while popping.
module fb_ram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_W,
  parameter int DATA_WIDTH  = PIX_W,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic                               video_off,
  input  logic [ADDR_WIDTH-1:0]              vga_addr,
  output logic [DATA_WIDTH-1:0]              vga_rdata,
  fb_ram_arbiter_if.slave                    wr,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic                               ram_we,
  output logic [DATA_WIDTH-1:0]              ram_wdata,
  input  logic [DATA_WIDTH-1:0]              ram_rdata,
  output logic [$clog2(WFIFO_DEPTH+1)-1:0]   fifo_level
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]                        stall_cnt,
  output logic [15:0]                        drop_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  wr_entry_t fifo_din;
  wr_entry_t fifo_head;
  logic [$bits(wr_entry_t)-1:0] fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;

  slot_e     state_q;
  slot_e     slot_d;
  logic      rd_pend;

  assign wr.wr_ready = !fifo_full;
  assign fifo_push   = wr.wr_valid && !fifo_full;
  assign fifo_din    = '{addr: wr.wr_addr, data: wr.wr_data};
  assign fifo_head   = wr_entry_t'(fifo_dout);

  fb_wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A due read always takes the slot; a queued write only gets leftovers.
  always_comb begin
    slot_d   = IDLE;
    fifo_pop = 1'b0;
    if (clk_en && !video_off) begin
      slot_d = READ;
    end else if (!fifo_empty) begin
      slot_d   = WRITE;
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= slot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= (slot_d == WRITE);
      case (slot_d)
        READ: begin
          ram_addr <= vga_addr;
        end
        WRITE: begin
          ram_addr  <= fifo_head.addr;
          ram_wdata <= fifo_head.data;
        end
        default: begin
          ram_addr <= ram_addr;
        end
      endcase
    end
  end

  // state_q==READ means the RAM is addressed now; its data lands next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      vga_rdata <= '0;
    end else begin
      rd_pend <= (state_q == READ);
      if (rd_pend) begin
        vga_rdata <= ram_rdata;
      end
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (!fifo_empty && slot_d == READ && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (wr.wr_valid && fifo_full && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`else
  // Counters are not built; ports and state are absent.
`endif

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Directed bench for fb_ram_arbiter with a write scoreboard and a behavioural sync RAM.
module tb_fb_ram_arbiter;
  import fb_arb_pkg::*;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          clk_en    = 1'b0;
  logic          video_off = 1'b0;
  logic [AW-1:0] vga_addr  = '0;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [LW-1:0] fifo_level;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   drop_cnt;
`endif

  fb_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

  fb_ram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .WFIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .video_off  (video_off),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .wr         (wr_if),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .fifo_level (fifo_level)
`ifdef FB_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
    return (a == 19'h00123) ? 8'hA5 : (a[7:0] + 8'h11);
  endfunction

  // Synchronous RAM: one cycle from ram_addr to ram_rdata.
  always @(posedge clk) ram_rdata <= pix_of(ram_addr);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_if.wr_valid = v;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
  endtask

  // Scoreboard: accepted writes queued, every ram_we pulse must match the head.
  always @(negedge clk) begin
    ent_t e;
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ram_we", 32'(ram_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_order_addr", 32'(ram_addr), 32'(e.a));
        chk("wr_order_data", 32'(ram_wdata), 32'(e.d));
      end
    end
    if (!rst && wr_if.wr_valid && wr_if.wr_ready) begin
      exp_q.push_back('{a: wr_if.wr_addr, d: wr_if.wr_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rd_addrs [3];
    logic [DW-1:0] held;
    int            k;

    // Reset held 3 cycles with a writer already requesting.
    drive_wr(1'b1, 19'h00055, 8'h99);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ram_we", 32'(ram_we), 32'd0);
    end
    rst = 1'b0;
    drive_wr(1'b0, '0, '0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_vga_rdata", 32'(vga_rdata), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
`ifdef FB_ARB_STATS_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Read path: one pixel strobe every 4 cycles.
    rd_addrs = '{19'h00123, 19'h4AFFF, 19'h00000};
    held = 8'h00;
    foreach (rd_addrs[i]) begin
      vga_addr = rd_addrs[i];
      clk_en   = 1'b1;
      step();
      clk_en = 1'b0;
      chk("rd_ram_addr", 32'(ram_addr), 32'(rd_addrs[i]));
      chk("rd_ram_we", 32'(ram_we), 32'd0);
      step();
      chk("rd_hold_t2", 32'(vga_rdata), 32'(held));
      step();
      chk("rd_data_t3", 32'(vga_rdata), 32'(pix_of(rd_addrs[i])));
      held = pix_of(rd_addrs[i]);
      step();
    end

    // Collision: queued write yields to a due read, then issues next cycle.
    drive_wr(1'b1, 19'h00010, 8'h3C);
    step();
    drive_wr(1'b0, '0, '0);
    clk_en   = 1'b1;
    vga_addr = 19'h00123;
    chk("col_level", 32'(fifo_level), 32'd1);
    step();
    clk_en = 1'b0;
    chk("col_read_addr", 32'(ram_addr), 32'h123);
    chk("col_read_we", 32'(ram_we), 32'd0);
    step();
    chk("col_write_we", 32'(ram_we), 32'd1);
    chk("col_write_addr", 32'(ram_addr), 32'h10);
    chk("col_write_data", 32'(ram_wdata), 32'h3C);
    step(2);
    chk("col_vga_rdata", 32'(vga_rdata), 32'hA5);

    // Full: reads every cycle starve the FIFO while five entries are offered.
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_wr(1'b1, 19'h00100 + AW'(i), 8'h80 + DW'(i));
      step();
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    drive_wr(1'b1, 19'h00104, 8'h84);
    step(2);
    chk("full_hold_level", 32'(fifo_level), 32'd4);
    chk("full_hold_we", 32'(ram_we), 32'd0);
`ifdef FB_ARB_STATS_EN
    chk("stall_cnt_nonzero", 32'(stall_cnt != 16'd0), 32'd1);
    chk("drop_cnt_ge1", 32'(drop_cnt >= 16'd1), 32'd1);
`endif
    clk_en = 1'b0;
    step();
    chk("full_pop_refuses_push", 32'(fifo_level), 32'd3);
    chk("full_ready_after_pop", 32'(wr_if.wr_ready), 32'd1);
    step();
    chk("fifth_accepted", 32'(fifo_level), 32'd3);
    drive_wr(1'b0, '0, '0);
    k = 0;
    while (fifo_level != '0 && k < 20) begin
      step();
      k++;
    end
    chk("full_drained", 32'(fifo_level), 32'd0);
    step(2);
    chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Blanking: three queued writes drain back-to-back, no read issued.
    clk_en   = 1'b1;
    vga_addr = 19'h00123;
    drive_wr(1'b1, 19'h00040, 8'h11);
    step();
    drive_wr(1'b1, 19'h00041, 8'h22);
    step();
    drive_wr(1'b1, 19'h00041, 8'h33);
    step();
    drive_wr(1'b0, '0, '0);
    chk("blank_level", 32'(fifo_level), 32'd3);
    video_off = 1'b1;
    vga_addr  = 19'h00000;
    step();
    chk("blank_we_0", 32'(ram_we), 32'd1);
    clk_en = 1'b0;
    step();
    chk("blank_we_1", 32'(ram_we), 32'd1);
    clk_en = 1'b1;
    step();
    chk("blank_we_2", 32'(ram_we), 32'd1);
    chk("blank_level_0", 32'(fifo_level), 32'd0);
    clk_en = 1'b0;
    step();
    chk("blank_we_done", 32'(ram_we), 32'd0);
    chk("idle_addr_hold", 32'(ram_addr), 32'h41);
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    step(3);
    chk("blank_vga_hold", 32'(vga_rdata), 32'hA5);
    chk("blank_sb_empty", 32'(exp_q.size()), 32'd0);
    video_off = 1'b0;

    // Reset mid-drain: queued writes are dropped.
    clk_en = 1'b1;
    drive_wr(1'b1, 19'h00200, 8'hE1);
    step();
    drive_wr(1'b1, 19'h00201, 8'hE2);
    step();
    drive_wr(1'b0, '0, '0);
    chk("mid_level", 32'(fifo_level), 32'd2);
    rst    = 1'b1;
    clk_en = 1'b0;
    exp_q.delete();
    step();
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_we", 32'(ram_we), 32'd0);
    end
    chk("post_rst_ready", 32'(wr_if.wr_ready), 32'd1);
`ifdef FB_ARB_STATS_EN
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);
    chk("post_rst_drop", 32'(drop_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
